// File: rtl/nand_flash_controller_if.sv
// Host-side handshake bundle for the NAND flash controller: the operation
// request, the program data stream and the read data stream plus completion.
interface nand_flash_controller_if #(
    parameter int DIOWidth = 16
);
    logic                req;
    logic [1:0]          op;
    logic [DIOWidth-1:0] addr;
    logic                abort;
    logic [DIOWidth-1:0] wrData;
    logic                wrReady;
    logic [DIOWidth-1:0] rdData;
    logic                rdValid;
    logic                busy;
    logic                done;
    logic                error;

    // Host side: issues operations and streams program data
    modport master (
        output req, op, addr, abort, wrData,
        input  wrReady, rdData, rdValid, busy, done, error
    );

    // Controller side
    modport slave (
        input  req, op, addr, abort, wrData,
        output wrReady, rdData, rdValid, busy, done, error
    );
endinterface

// File: rtl/nand_flash_controller.sv
// NAND flash controller: sequences erase / page program / page read on a
// multiplexed tri-state bus (command latch, address latch, data beats), then
// waits for the memory status handshake with a timeout.
module nand_flash_controller #(
    parameter int DIOWidth      = 16,
    parameter int PageSize      = 2048,
    parameter int StatusTimeout = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    nand_flash_controller_if.slave host,
    inout  wire  [DIOWidth-1:0]  DIO,
    output logic                 cEn,
    output logic                 CLE,
    output logic                 ALE,
    output logic                 wEn,
    output logic                 rEn,
    input  logic                 status
);

    localparam int BeatW = (PageSize > 1) ? $clog2(PageSize) : 1;
    localparam int TmoW  = $clog2(StatusTimeout + 1);

    // Program/read work on whole pages, erase on whole blocks
    localparam logic [DIOWidth-1:0] PageMask  = DIOWidth'(16'hF800);
    localparam logic [DIOWidth-1:0] BlockMask = DIOWidth'(16'hE000);

    localparam logic [1:0] OpErase   = 2'd0;
    localparam logic [1:0] OpProgram = 2'd1;
    localparam logic [1:0] OpInvalid = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_CMD,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_WAIT_ST,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q;
    logic [DIOWidth-1:0] addr_q;
    logic [BeatW-1:0]    beat_q;
    logic [TmoW-1:0]     tmo_q;
    logic                st_seen_q;   // status already seen on the last data beat
    logic                err_q;       // DONE will report an error
    logic                inv_q;       // current DONE comes from an invalid op
    logic [DIOWidth-1:0] rd_data_q;
    logic                rd_valid_q;

    logic                dio_oe;
    logic [DIOWidth-1:0] dio_out;
    logic                wr_ready;
    logic [DIOWidth-1:0] aligned_addr;
    logic                last_beat;
    logic                tmo_last;
    logic                status_ok;

    assign aligned_addr = (op_q == OpErase) ? (addr_q & BlockMask) : (addr_q & PageMask);
    assign last_beat    = (beat_q == BeatW'(PageSize - 1));
    assign tmo_last     = (tmo_q == TmoW'(StatusTimeout - 1));
    assign status_ok    = status | st_seen_q;

    // Bus is released unless the controller is in CMD, ADDR or WRITE
    assign DIO = dio_oe ? dio_out : {DIOWidth{1'bz}};

    assign host.wrReady = wr_ready;
    assign host.rdData  = rd_data_q;
    assign host.rdValid = rd_valid_q;
    assign host.busy    = (state_q != S_IDLE);
    assign host.done    = (state_q == S_DONE);
    assign host.error   = (state_q == S_DONE) & err_q;

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and memory-side strobes, decoded from the current state
    always_comb begin
        state_d  = state_q;
        cEn      = 1'b0;
        CLE      = 1'b0;
        ALE      = 1'b0;
        wEn      = 1'b0;
        rEn      = 1'b0;
        wr_ready = 1'b0;
        dio_oe   = 1'b0;
        dio_out  = '0;
        case (state_q)
            S_IDLE: begin
                if (host.req) state_d = (host.op == OpInvalid) ? S_DONE : S_WAKE;
            end
            S_WAKE: begin
                cEn     = 1'b1;
                state_d = S_CMD;
            end
            S_CMD: begin
                cEn     = 1'b1;
                CLE     = 1'b1;
                dio_oe  = 1'b1;
                dio_out = DIOWidth'(op_q);
                state_d = S_ADDR;
            end
            S_ADDR: begin
                cEn     = 1'b1;
                ALE     = 1'b1;
                dio_oe  = 1'b1;
                dio_out = aligned_addr;
                if (op_q == OpErase)        state_d = S_WAIT_ST;
                else if (op_q == OpProgram) state_d = S_WRITE;
                else                        state_d = S_READ;
            end
            S_WRITE: begin
                cEn      = 1'b1;
                wEn      = 1'b1;
                wr_ready = 1'b1;
                dio_oe   = 1'b1;
                dio_out  = host.wrData;
                if (host.abort || last_beat) state_d = S_WAIT_ST;
            end
            S_READ: begin
                cEn = 1'b1;
                rEn = 1'b1;
                if (host.abort || last_beat) state_d = S_WAIT_ST;
            end
            S_WAIT_ST: begin
                cEn = 1'b1;
                if (status_ok || tmo_last) state_d = S_DONE;
            end
            S_DONE: begin
                cEn     = ~inv_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operation context, beat/timeout counters and status latch
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            op_q      <= '0;
            addr_q    <= '0;
            beat_q    <= '0;
            tmo_q     <= '0;
            st_seen_q <= 1'b0;
            err_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host.req) begin
                        if (host.op == OpInvalid) begin
                            inv_q <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            op_q      <= host.op;
                            addr_q    <= host.addr;
                            inv_q     <= 1'b0;
                            err_q     <= 1'b0;
                            beat_q    <= '0;
                            tmo_q     <= '0;
                            st_seen_q <= 1'b0;
                        end
                    end
                end
                S_WRITE, S_READ: begin
                    if (state_d == state_q) beat_q    <= beat_q + 1'b1;
                    else                    st_seen_q <= status;
                end
                S_WAIT_ST: begin
                    if (state_d == S_WAIT_ST) tmo_q <= tmo_q + 1'b1;
                    else if (!status_ok)      err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read capture: one word per READ cycle, qualified on the following cycle
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == S_READ);
            if (state_q == S_READ) rd_data_q <= DIO;
        end
    end

endmodule

// File: tb/tb_nand_flash_controller.sv
// Self-checking bench for nand_flash_controller with a one-page memory model
// and a queue of expected bus/read words.
module tb_nand_flash_controller;
    localparam int W  = 16;
    localparam int PS = 2048;
    localparam int TO = 16;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    nand_flash_controller_if #(.DIOWidth(W)) hif();

    wire  [W-1:0] DIO;
    logic cEn, CLE, ALE, wEn, rEn;
    logic status = 1'b0;
    logic probe  = 1'b0;

    logic [W-1:0] page [PS];
    logic [10:0]  rd_idx;

    // Memory drives the bus while rEn is high; probe drives a marker so a
    // released bus is visible as that marker.
    assign DIO = probe ? 16'hBEEF : (rEn ? page[rd_idx] : {W{1'bz}});

    // Memory read pointer advances once per rEn cycle
    always @(posedge clk or negedge rstN) begin
        if (!rstN)    rd_idx <= '0;
        else if (rEn) rd_idx <= rd_idx + 1'b1;
        else          rd_idx <= '0;
    end

    nand_flash_controller #(.DIOWidth(W), .PageSize(PS), .StatusTimeout(TO)) dut (
        .clk(clk), .rstN(rstN), .host(hif), .DIO(DIO),
        .cEn(cEn), .CLE(CLE), .ALE(ALE), .wEn(wEn), .rEn(rEn), .status(status)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a);
        hif.req = 1'b1; hif.op = o; hif.addr = a;
        tick();
        hif.req = 1'b0; hif.op = 2'd0; hif.addr = '0;
    endtask

    task automatic wait_done(input int bound, output int cyc, output logic got, output logic err);
        cyc = 0;
        while (!hif.done && cyc < bound) begin
            tick();
            cyc++;
        end
        got = hif.done;
        err = hif.error;
    endtask

    function automatic logic [W-1:0] pattern(input int i);
        return W'(i * 37) ^ 16'hA5A5;
    endfunction

    task automatic test_reset();
        rstN = 1'b0; probe = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({cEn, CLE, ALE, wEn, rEn} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 00000", {cEn, CLE, ALE, wEn, rEn});
        end
        n_tests++;
        if ({hif.wrReady, hif.rdValid, hif.busy, hif.done, hif.error} !== 5'b0) begin
            n_fail++; $display("FAIL reset_host: got %b want 00000",
                               {hif.wrReady, hif.rdValid, hif.busy, hif.done, hif.error});
        end
        n_tests++;
        if (hif.rdData !== 16'h0) begin
            n_fail++; $display("FAIL reset_rddata: got %h want 0000", hif.rdData);
        end
        n_tests++;
        if (DIO !== 16'hBEEF) begin
            n_fail++; $display("FAIL reset_dio_released: got %h want beef", DIO);
        end
        probe = 1'b0;
        rstN  = 1'b1;
        tick();
        n_tests++;
        if ({hif.busy, hif.done, cEn} !== 3'b0) begin
            n_fail++; $display("FAIL reset_idle: got %b want 000", {hif.busy, hif.done, cEn});
        end
    endtask

    task automatic test_erase();
        int cyc; logic got, err;
        start_op(2'd0, 16'h3456);
        n_tests++;
        if ({cEn, CLE, ALE, wEn, rEn, hif.busy} !== 6'b100001) begin
            n_fail++; $display("FAIL erase_wake: got %b want 100001", {cEn, CLE, ALE, wEn, rEn, hif.busy});
        end
        tick();
        n_tests++;
        if ({cEn, CLE, ALE, wEn, rEn} !== 5'b11000 || DIO !== 16'h0000) begin
            n_fail++; $display("FAIL erase_cmd: got %b dio %h want 11000 dio 0000", {cEn, CLE, ALE, wEn, rEn}, DIO);
        end
        tick();
        n_tests++;
        if ({cEn, CLE, ALE, wEn, rEn} !== 5'b10100 || DIO !== 16'h2000) begin
            n_fail++; $display("FAIL erase_addr: got %b dio %h want 10100 dio 2000", {cEn, CLE, ALE, wEn, rEn}, DIO);
        end
        tick();
        status = 1'b1;
        wait_done(8, cyc, got, err);
        n_tests++;
        if (!got || err !== 1'b0 || cyc != 1) begin
            n_fail++; $display("FAIL erase_done: got done %b err %b after %0d want 1 0 after 1", got, err, cyc);
        end
        status = 1'b0;
        tick();
        n_tests++;
        if ({hif.done, hif.busy, cEn} !== 3'b0) begin
            n_fail++; $display("FAIL erase_idle: got %b want 000", {hif.done, hif.busy, cEn});
        end
    endtask

    task automatic test_program(input int abort_at);
        int cnt; int n_exp; int cyc; logic got, err; logic [W-1:0] e;
        exp_q.delete();
        n_exp = (abort_at < 0) ? PS : abort_at + 1;
        for (int i = 0; i < n_exp; i++) exp_q.push_back(W'(i));
        hif.wrData = '0;
        start_op(2'd1, 16'h1234);
        tick();
        tick();
        n_tests++;
        if (ALE !== 1'b1 || DIO !== 16'h1000) begin
            n_fail++; $display("FAIL prog_addr: got ale %b dio %h want 1 1000", ALE, DIO);
        end
        tick();
        cnt = 0;
        while (hif.wrReady && cnt < PS + 4) begin
            hif.wrData = W'(cnt);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
            n_tests++;
            if (DIO !== e || wEn !== 1'b1 || rEn !== 1'b0) begin
                n_fail++; $display("FAIL prog_beat%0d: got dio %h wEn %b rEn %b want dio %h wEn 1 rEn 0", cnt, DIO, wEn, rEn, e);
            end
            if (cnt < PS) page[cnt] = DIO;
            if (cnt == abort_at) hif.abort = 1'b1;
            cnt++;
            tick();
            hif.abort = 1'b0;
        end
        n_tests++;
        if (cnt != n_exp || wEn !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL prog_beats: got %0d beats wEn %b want %0d beats wEn 0", cnt, wEn, n_exp);
        end
        hif.wrData = '0;
        status = 1'b1;
        wait_done(5, cyc, got, err);
        n_tests++;
        if (!got || err !== 1'b0) begin
            n_fail++; $display("FAIL prog_done: got done %b err %b want 1 0", got, err);
        end
        status = 1'b0;
        tick();
    endtask

    task automatic test_read(input bit preload, input bit late_status);
        int n_ren; int n_rv; int cyc; logic got, err; logic excl_bad; logic [W-1:0] e;
        exp_q.delete();
        for (int i = 0; i < PS; i++) begin
            if (preload) page[i] = pattern(i);
            exp_q.push_back(preload ? pattern(i) : W'(i));
        end
        start_op(2'd2, 16'h1000);
        tick();
        tick();
        n_tests++;
        if (ALE !== 1'b1 || DIO !== 16'h1000) begin
            n_fail++; $display("FAIL read_addr: got ale %b dio %h want 1 1000", ALE, DIO);
        end
        tick();
        n_ren = 0; n_rv = 0; excl_bad = 1'b0;
        for (int c = 0; c < PS + 8; c++) begin
            if (wEn && rEn) excl_bad = 1'b1;
            if (hif.rdValid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
                n_tests++;
                if (hif.rdData !== e) begin
                    n_fail++; $display("FAIL read_word%0d: got %h want %h", n_rv, hif.rdData, e);
                end
                n_rv++;
            end
            if (rEn) n_ren++;
            if (late_status) status = (rEn && n_ren == PS);
            if (!rEn && !hif.rdValid && n_ren > 0) break;
            tick();
        end
        n_tests++;
        if (n_ren != PS || n_rv != PS || excl_bad) begin
            n_fail++; $display("FAIL read_count: got ren %0d valid %0d overlap %b want %0d %0d 0", n_ren, n_rv, excl_bad, PS, PS);
        end
        if (!late_status) status = 1'b1;
        wait_done(5, cyc, got, err);
        n_tests++;
        if (!got || err !== 1'b0) begin
            n_fail++; $display("FAIL read_done: got done %b err %b want 1 0", got, err);
        end
        status = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int cyc; logic seen;
        start_op(2'd0, 16'hFFFF);
        tick();
        tick();
        n_tests++;
        if (ALE !== 1'b1 || DIO !== 16'hE000) begin
            n_fail++; $display("FAIL tmo_addr_mask: got ale %b dio %h want 1 e000", ALE, DIO);
        end
        tick();
        // A request while busy must be ignored
        hif.req = 1'b1; hif.op = 2'd3;
        cyc = 0;
        while (!hif.done && cyc < 40) begin
            tick();
            hif.req = 1'b0; hif.op = 2'd0;
            cyc++;
        end
        n_tests++;
        if (hif.done !== 1'b1 || hif.error !== 1'b1 || cyc != TO) begin
            n_fail++; $display("FAIL tmo_error: got done %b err %b after %0d want 1 1 after %0d", hif.done, hif.error, cyc, TO);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (hif.done || hif.busy) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL busy_req_ignored: got extra activity 1 want 0");
        end
    endtask

    task automatic test_invalid();
        start_op(2'd3, 16'h1234);
        n_tests++;
        if ({hif.done, hif.error, cEn, CLE, ALE, wEn, rEn} !== 7'b1100000) begin
            n_fail++; $display("FAIL invalid_op: got %b want 1100000", {hif.done, hif.error, cEn, CLE, ALE, wEn, rEn});
        end
        probe = 1'b1;
        #1;
        n_tests++;
        if (DIO !== 16'hBEEF) begin
            n_fail++; $display("FAIL invalid_dio: got %h want beef", DIO);
        end
        probe = 1'b0;
        tick();
        n_tests++;
        if ({hif.done, hif.error, hif.busy} !== 3'b0) begin
            n_fail++; $display("FAIL invalid_after: got %b want 000", {hif.done, hif.error, hif.busy});
        end
    endtask

    task automatic test_reset_mid_read();
        int n_ren; logic seen;
        for (int i = 0; i < PS; i++) page[i] = pattern(i);
        start_op(2'd2, 16'h1000);
        tick();
        tick();
        tick();
        n_ren = 0;
        while (rEn && n_ren < 500) begin
            tick();
            n_ren++;
        end
        rstN = 1'b0;
        #1;
        n_tests++;
        if ({cEn, CLE, ALE, wEn, rEn, hif.wrReady, hif.rdValid, hif.busy, hif.done, hif.error} !== 10'b0
            || hif.rdData !== 16'h0 || n_ren != 500) begin
            n_fail++; $display("FAIL async_reset: got %b rd %h beat %0d want 0 0000 beat 500",
                {cEn, CLE, ALE, wEn, rEn, hif.wrReady, hif.rdValid, hif.busy, hif.done, hif.error}, hif.rdData, n_ren);
        end
        probe = 1'b1;
        #1;
        n_tests++;
        if (DIO !== 16'hBEEF) begin
            n_fail++; $display("FAIL async_reset_dio: got %h want beef", DIO);
        end
        probe = 1'b0;
        tick();
        rstN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (hif.done || hif.busy || cEn) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL post_reset_idle: got activity 1 want 0");
        end
        test_read(1'b1, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        hif.req = 1'b0; hif.op = 2'd0; hif.addr = '0; hif.abort = 1'b0; hif.wrData = '0;
        test_reset();
        test_erase();
        test_program(-1);
        test_read(1'b0, 1'b0);
        test_read(1'b1, 1'b1);
        test_program(100);
        test_timeout();
        test_invalid();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
